// File: rtl/lif_pkg.sv
// lif_pkg: shared encodings, FSM states, reset constants and saturation helper for the LIF layer
package lif_pkg;
    localparam logic [1:0] SEL_INPUTS  = 2'b00;
    localparam logic [1:0] SEL_WEIGHTS = 2'b01;
    localparam logic [1:0] SEL_THRESH  = 2'b10;
    localparam logic [1:0] SEL_PARAMS  = 2'b11;
    localparam int THRESH_INIT = 5;
    localparam int WEIGHT_INIT = 1;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    function automatic int sat(input int v, input int bits);
        int lo;
        int hi;
        lo = -(1 <<< (bits - 1));
        hi = (1 <<< (bits - 1)) - 1;
        return v < lo ? lo : v > hi ? hi : v;
    endfunction
endpackage

// File: rtl/lif_update.sv
// lif_update: one neuron's combinational integrate, leak, saturate, fire and refractory step
module lif_update
    import lif_pkg::*;
#(
    parameter int N_INPUTS = 16,
    parameter int W_BITS   = 2,
    parameter int MEM_BITS = 8,
    parameter int REF_BITS = 3
) (
    input  logic [N_INPUTS-1:0]        inputs,
    input  logic [N_INPUTS*W_BITS-1:0] weights,
    input  logic signed [MEM_BITS-1:0] mem,
    input  logic [REF_BITS-1:0]        ref_cnt,
    input  logic [MEM_BITS-2:0]        thresh,
    input  logic [2:0]                 shift,
    input  logic [REF_BITS-1:0]        ref_period,
    output logic signed [MEM_BITS-1:0] mem_next,
    output logic [REF_BITS-1:0]        ref_next,
    output logic                       spike
);
    localparam int SUM_W = $clog2(N_INPUTS) + W_BITS + 1;
    logic signed [SUM_W-1:0] sum;
    logic signed [MEM_BITS-1:0] leak;
    int v;
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_INPUTS; i++)
            sum = inputs[i] ? sum + SUM_W'($signed(weights[i*W_BITS +: W_BITS])) : sum;
        leak = shift == 3'd0 ? '0 : mem >>> shift;
        v = sat(int'(mem) - int'(leak) + int'(sum), MEM_BITS);
        spike = ref_cnt == '0 && v >= int'(thresh);
        mem_next = ref_cnt != '0 ? '0 : spike ? MEM_BITS'(v - int'(thresh)) : MEM_BITS'(v);
        ref_next = ref_cnt != '0 ? ref_cnt - 1'b1 : spike ? ref_period : '0;
    end
endmodule

// File: rtl/lif_layer_tdm.sv
// lif_layer_tdm: LIF neuron layer, one shared update datapath stepping through the neurons one per clock
module lif_layer_tdm
    import lif_pkg::*;
#(
    parameter int N_INPUTS  = 16,
    parameter int N_NEURONS = 4,
    parameter int W_BITS    = 2,
    parameter int MEM_BITS  = 8,
    parameter int REF_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_sel,
    input  logic [7:0]           cfg_data,
    input  logic                 step,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes
);
    localparam int W_TOT = N_NEURONS * N_INPUTS * W_BITS;
    localparam int W_ROW = N_INPUTS * W_BITS;
    localparam int K_W   = $clog2(N_NEURONS);
    state_t state, state_next;
    logic [K_W-1:0] k;
    logic last;
    logic [N_INPUTS-1:0] inputs;
    logic [W_TOT-1:0] weights;
    logic [MEM_BITS-2:0] thresh;
    logic [2:0] shift;
    logic [REF_BITS-1:0] ref_period;
    logic signed [MEM_BITS-1:0] mem [N_NEURONS];
    logic [REF_BITS-1:0] ref_cnt [N_NEURONS];
    logic [N_NEURONS-1:0] spk_acc;
    logic signed [MEM_BITS-1:0] mem_next;
    logic [REF_BITS-1:0] ref_next;
    logic spike;
    assign last = k == K_W'(N_NEURONS - 1);
    assign cfg_ready = state == IDLE;
    assign busy = state != IDLE;
    assign done = state == FINISH;
    always_comb begin
        state_next = state;
        state_next = state == IDLE ? (step && !cfg_valid ? RUN : IDLE)
                   : state == RUN  ? (last ? FINISH : RUN)
                   : IDLE;
    end
    lif_update #(
        .N_INPUTS(N_INPUTS), .W_BITS(W_BITS), .MEM_BITS(MEM_BITS), .REF_BITS(REF_BITS)
    ) u_update (
        .inputs(inputs),
        .weights(weights[k*W_ROW +: W_ROW]),
        .mem(mem[k]),
        .ref_cnt(ref_cnt[k]),
        .thresh(thresh),
        .shift(shift),
        .ref_period(ref_period),
        .mem_next(mem_next),
        .ref_next(ref_next),
        .spike(spike)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k <= '0;
            inputs <= '0;
            weights <= {(N_NEURONS*N_INPUTS){W_BITS'(WEIGHT_INIT)}};
            thresh <= (MEM_BITS-1)'(THRESH_INIT);
            shift <= '0;
            ref_period <= '0;
            spk_acc <= '0;
            spikes <= '0;
            for (int n = 0; n < N_NEURONS; n++) begin
                mem[n] <= '0;
                ref_cnt[n] <= '0;
            end
        end else begin
            state <= state_next;
            if (cfg_valid && cfg_ready) begin
                case (cfg_sel)
                    SEL_INPUTS:  inputs <= {inputs[N_INPUTS-9:0], cfg_data};
                    SEL_WEIGHTS: weights <= {weights[W_TOT-9:0], cfg_data};
                    SEL_THRESH:  thresh <= cfg_data[MEM_BITS-2:0];
                    default: begin
                        shift <= cfg_data[2:0];
                        ref_period <= cfg_data[4 +: REF_BITS];
                    end
                endcase
            end
            if (state == RUN) begin
                mem[k] <= mem_next;
                ref_cnt[k] <= ref_next;
                spk_acc[k] <= spike;
                k <= last ? '0 : k + 1'b1;
            end
            // publish the whole vector at once so spikes never shows a half-updated timestep
            if (state == FINISH) spikes <= spk_acc;
        end
    end
endmodule

// File: tb/tb_lif_layer_tdm.sv
// tb_lif_layer_tdm: directed vector table plus hand sequences for saturation, config blocking and async reset
module tb_lif_layer_tdm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_valid = 1'b0;
    logic [1:0] cfg_sel = 2'b00;
    logic [7:0] cfg_data = 8'h00;
    logic step = 1'b0;
    logic cfg_ready, busy, done;
    logic [3:0] spikes;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic [15:0] in;
        logic [7:0]  th;
        logic [7:0]  prm;
        logic [3:0]  spk;
        int          m0;
        int          m1;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    lif_layer_tdm dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .step(step), .busy(busy),
        .done(done), .spikes(spikes)
    );

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [7:0] data);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_sel = sel;
        cfg_data = data;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic run_step(output int lat);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int seen;
        logic [7:0] b;
        // rst, inputs, thresh byte, params byte, spikes, mem[0], mem[1]
        tv.push_back('{1'b1, 16'hFFFF, 8'h05, 8'h00, 4'hF, 11, 11});
        tv.push_back('{1'b1, 16'h000F, 8'h14, 8'h00, 4'h0, 4, 4});
        tv.push_back('{1'b0, 16'h000F, 8'h14, 8'h00, 4'h0, 8, 8});
        tv.push_back('{1'b0, 16'h000F, 8'h14, 8'h00, 4'h0, 12, 12});
        tv.push_back('{1'b0, 16'h000F, 8'h14, 8'h00, 4'h0, 16, 16});
        tv.push_back('{1'b0, 16'h000F, 8'h14, 8'h00, 4'hF, 0, 0});
        tv.push_back('{1'b1, 16'h000F, 8'h14, 8'h00, 4'h0, 4, 4});
        tv.push_back('{1'b0, 16'h000F, 8'h14, 8'h00, 4'h0, 8, 8});
        tv.push_back('{1'b0, 16'h000F, 8'h14, 8'h00, 4'h0, 12, 12});
        tv.push_back('{1'b0, 16'h0000, 8'h14, 8'h01, 4'h0, 6, 6});
        tv.push_back('{1'b0, 16'h0000, 8'h14, 8'h01, 4'h0, 3, 3});
        tv.push_back('{1'b0, 16'h0000, 8'h14, 8'h01, 4'h0, 2, 2});
        tv.push_back('{1'b0, 16'h0000, 8'h14, 8'h01, 4'h0, 1, 1});
        tv.push_back('{1'b0, 16'h0000, 8'h14, 8'h01, 4'h0, 1, 1});
        tv.push_back('{1'b1, 16'hFFFF, 8'h05, 8'h20, 4'hF, 11, 11});
        tv.push_back('{1'b0, 16'hFFFF, 8'h05, 8'h20, 4'h0, 0, 0});
        tv.push_back('{1'b0, 16'hFFFF, 8'h05, 8'h20, 4'h0, 0, 0});
        tv.push_back('{1'b0, 16'hFFFF, 8'h05, 8'h20, 4'hF, 11, 11});
        tv.push_back('{1'b0, 16'hFFFF, 8'h05, 8'h20, 4'h0, 0, 0});
        tv.push_back('{1'b0, 16'hFFFF, 8'h05, 8'h20, 4'h0, 0, 0});
        tv.push_back('{1'b0, 16'hFFFF, 8'h05, 8'h20, 4'hF, 11, 11});
        tv.push_back('{1'b1, 16'h0000, 8'h00, 8'h00, 4'hF, 0, 0});
        tv.push_back('{1'b1, 16'hFFFF, 8'hFF, 8'h00, 4'h0, 16, 16});
        for (int s = 2; s <= 7; s++)
            tv.push_back('{1'b0, 16'hFFFF, 8'hFF, 8'h00, 4'h0, 16 * s, 16 * s});
        tv.push_back('{1'b0, 16'hFFFF, 8'hFF, 8'h00, 4'hF, 0, 0});

        reset_dut();
        @(negedge clk);
        chk("reset cfg_ready", 32'(cfg_ready), 1);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset spikes", 32'(spikes), 0);

        foreach (tv[r]) begin
            if (tv[r].rst) reset_dut();
            cfg(2'b00, tv[r].in[15:8]);
            cfg(2'b00, tv[r].in[7:0]);
            cfg(2'b10, tv[r].th);
            cfg(2'b11, tv[r].prm);
            run_step(lat);
            chk($sformatf("row%0d latency", r), lat, 5);
            chk($sformatf("row%0d spikes", r), 32'(spikes), 32'(tv[r].spk));
            chk($sformatf("row%0d mem0", r), int'(dut.mem[0]), tv[r].m0);
            chk($sformatf("row%0d mem1", r), int'(dut.mem[1]), tv[r].m1);
        end

        // neuron 1 weights all -2: drives its membrane to the negative rail
        reset_dut();
        for (int i = 15; i >= 0; i--) begin
            b = (i >= 4 && i <= 7) ? 8'hAA : 8'h55;
            cfg(2'b01, b);
        end
        cfg(2'b00, 8'hFF);
        cfg(2'b00, 8'hFF);
        for (int s = 1; s <= 5; s++) begin
            run_step(lat);
            chk($sformatf("sat%0d spikes", s), 32'(spikes), 32'(4'b1101));
            chk($sformatf("sat%0d mem1", s), int'(dut.mem[1]), (s < 4) ? -32 * s : -128);
            chk($sformatf("sat%0d mem0", s), int'(dut.mem[0]), 11 * s);
            chk($sformatf("sat%0d mem2", s), int'(dut.mem[2]), 11 * s);
        end

        // step held with cfg_valid: config wins, no timestep starts
        reset_dut();
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_sel = 2'b10;
        cfg_data = 8'h05;
        step = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy) seen++;
        end
        chk("step blocked by cfg", seen, 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("step after cfg busy", 32'(busy), 1);
        step = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = 8'h03;
        chk("cfg_ready in RUN", 32'(cfg_ready), 0);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("done reached with cfg held", 32'(done), 1);
        chk("thresh held during run", 32'(dut.thresh), 5);
        @(posedge clk);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        chk("held beat accepted", 32'(dut.thresh), 3);

        // async reset in the middle of a timestep
        reset_dut();
        cfg(2'b00, 8'hFF);
        cfg(2'b00, 8'hFF);
        run_step(lat);
        chk("pre-reset spikes", 32'(spikes), 32'hF);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 0);
        chk("async rst done", 32'(done), 0);
        chk("async rst cfg_ready", 32'(cfg_ready), 1);
        chk("async rst spikes", 32'(spikes), 0);
        chk("async rst mem0", int'(dut.mem[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("no done after reset", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
